uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per UART bit; legal range >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port rx_in, input, 1, asynchronous serial line; idle high.
REQ-008 SHALL have port m_data, output, DATA_BITS, received word, LSB received first.
REQ-009 SHALL have port m_valid, output, 1, m_data holds an unconsumed word.
REQ-010 SHALL have port m_ready, input, 1, consumer accepts m_data.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse on a low stop bit.
REQ-012 SHALL have port parity_err, output, 1, one-cycle pulse on a parity mismatch.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a good frame is dropped.
REQ-014 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-015 SHALL pass rx_in through a 2-FF synchronizer (rx_s); both flops reset to 1; all decisions use rx_s.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PAR, STOP with a bit-period counter (C = CLKS_PER_BIT, H = C/2 integer) and a bit index.
REQ-017 IDLE: on rx_s == 0, go to START and clear counter; edge t0 is the first edge sampling rx_s == 0.
REQ-018 Sampling: sample k (k = 0 start, 1..DATA_BITS data, then parity, then stops) is taken at edge t0 + H + k*C.
REQ-019 START: rx_s == 1 at the start sample is a glitch; return to IDLE with no output and no error pulse.
REQ-020 DATA: shift samples LSB-first into a DATA_BITS shift register; after the last data bit, go to PAR if PARITY != 0, else STOP.
REQ-021 PAR: compare the sample with the XOR of the data bits (even: equal; odd: inverted); record a mismatch flag.
REQ-022 STOP: sample STOP_BITS stop bits; any low sample marks a framing error; return to IDLE immediately after the final stop sample, without waiting a full bit.
REQ-023 Framing error: pulse frame_err for one cycle after the final stop sample; discard the word; it SHALL take precedence over parity_err, so only frame_err pulses.
REQ-024 Parity error only: pulse parity_err for one cycle; discard the word.
REQ-025 Good frame with m_valid == 0, or with m_valid && m_ready on the same cycle: load m_data and set m_valid on the edge after the final stop sample.
REQ-026 Good frame with m_valid && !m_ready: keep the old m_data, drop the new word, pulse overrun for one cycle.
REQ-027 Handshake: m_valid clears on the edge after m_valid && m_ready unless a new word loads on the same edge (REQ-025); m_data stays stable while m_valid && !m_ready.
REQ-028 busy SHALL rise on the edge after t0 and fall on the edge entering IDLE.
REQ-029 A new start bit detected in IDLE immediately after a stop bit SHALL be accepted (back-to-back frames).

Reset
REQ-030 On reset: FSM to IDLE, counters 0, synchronizer flops 1, m_data 0, m_valid/frame_err/parity_err/overrun/busy 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no pulses; reception restarts only on a new falling edge after reset deasserts.

Verification
REQ-032 C=4, 8N1, send 0xA5, m_ready=1 -> m_valid one cycle, m_data=0xA5, no error pulses.
REQ-033 rx_in low for 1 cycle only -> busy pulses briefly, no m_valid, no error pulses, back to IDLE.
REQ-034 8N1 frame 0x3C with stop bit 0 -> frame_err single pulse, m_valid stays 0.
REQ-035 PARITY=2, frame 0x01 with parity bit 0 -> parity_err pulse, no m_valid; same frame with parity bit 1 -> m_data=0x01.
REQ-036 m_ready=0, send 0x11 then 0x22 back-to-back -> m_data=0x11 held, overrun pulse after second frame; m_ready=1 -> m_valid clears.
REQ-037 Reset during data bit 3 of a frame -> all outputs 0; next frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with valid/ready output and error pulses
//
// Purpose: receives asynchronous serial frames (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits), oversampled at CLKS_PER_BIT clocks
// per bit, and presents each good word on a valid/ready output.
//
// Ports:
//   clk        - clock
//   reset      - synchronous, active-high reset
//   rx_in      - asynchronous serial line, idles high
//   m_data     - received word, first received bit in the LSB
//   m_valid    - m_data holds a word not yet accepted
//   m_ready    - consumer accepts m_data when high with m_valid
//   frame_err  - one-cycle pulse: a stop bit sampled low (word discarded)
//   parity_err - one-cycle pulse: parity mismatch, stop bits good (word discarded)
//   overrun    - one-cycle pulse: good word dropped because m_data was still held
//   busy       - high while a frame is being received

module uart_rx_param #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] D_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] S_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad;
  logic                 r_stop_bad;
  logic                 r_rx_m;
  logic                 r_rx_s;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_ovr;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_par_bad_nxt;
  logic                 w_stop_bad_nxt;
  logic                 w_done;
  logic                 w_sample;
  logic                 w_par_exp;
  logic                 w_frame_bad;
  logic                 w_ferr_evt;
  logic                 w_perr_evt;
  logic                 w_good;
  logic                 w_load;

  // Even parity: the parity bit equals the XOR of the data; odd: its inverse.
  assign w_par_exp = (PARITY == 2) ? (^r_shift) : ~(^r_shift);

  // Every sample after the start bit lands a full bit period after the previous one.
  assign w_sample = (r_cnt == C_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + CNT_W'(1);
    w_idx_nxt      = r_idx;
    w_shift_nxt    = r_shift;
    w_par_bad_nxt  = r_par_bad;
    w_stop_bad_nxt = r_stop_bad;
    w_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) begin
          w_state_nxt    = S_START;
          w_idx_nxt      = '0;
          w_par_bad_nxt  = 1'b0;
          w_stop_bad_nxt = 1'b0;
        end
      end
      S_START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (r_cnt == H_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_sample) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_idx == D_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_PAR: begin
        if (w_sample) begin
          w_cnt_nxt     = '0;
          w_par_bad_nxt = (r_rx_s != w_par_exp);
          w_state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if (w_sample) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_stop_bad_nxt = 1'b1;
          end
          // Leave on the final stop sample so a back-to-back start is not missed.
          if (r_idx == S_LAST) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The final stop sample is folded in here since r_stop_bad only covers earlier ones.
  assign w_frame_bad = r_stop_bad | ~r_rx_s;
  assign w_ferr_evt  = w_done & w_frame_bad;
  assign w_perr_evt  = w_done & ~w_frame_bad & r_par_bad;
  assign w_good      = w_done & ~w_frame_bad & ~r_par_bad;
  assign w_load      = w_good & (~r_valid | m_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
      r_stop_bad <= 1'b0;
      r_rx_m     <= 1'b1;
      r_rx_s     <= 1'b1;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_par_bad  <= w_par_bad_nxt;
      r_stop_bad <= w_stop_bad_nxt;
      r_rx_m     <= rx_in;
      r_rx_s     <= r_rx_m;
      r_ferr     <= w_ferr_evt;
      r_perr     <= w_perr_evt;
      r_ovr      <= w_good & r_valid & ~m_ready;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_data     = r_data;
  assign m_valid    = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign overrun    = r_ovr;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8N1 and 8E1 instances)

module tb_uart_rx_param;

  localparam int CPB = 4;

  logic       clk;
  logic       reset;
  logic       rx_a, rx_p;
  logic       m_ready_a, m_ready_p;
  logic [7:0] m_data_a, m_data_p;
  logic       m_valid_a, m_valid_p;
  logic       frame_err_a, frame_err_p;
  logic       parity_err_a, parity_err_p;
  logic       overrun_a, overrun_p;
  logic       busy_a, busy_p;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_exp_a[$];
  logic [7:0] q_exp_p[$];
  logic [7:0] q_obs_a[$];
  logic [7:0] q_obs_p[$];

  int n_valid_a = 0, n_ferr_a = 0, n_perr_a = 0, n_ovr_a = 0, n_busy_a = 0;
  int n_valid_p = 0, n_ferr_p = 0, n_perr_p = 0;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .reset(reset), .rx_in(rx_p),
    .m_data(m_data_p), .m_valid(m_valid_p), .m_ready(m_ready_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p), .busy(busy_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: accepted words go to the observed queues, pulses are counted per cycle.
  always @(negedge clk) begin
    if (m_valid_a && m_ready_a) q_obs_a.push_back(m_data_a);
    if (m_valid_p && m_ready_p) q_obs_p.push_back(m_data_p);
    n_valid_a = n_valid_a + int'(m_valid_a);
    n_ferr_a  = n_ferr_a + int'(frame_err_a);
    n_perr_a  = n_perr_a + int'(parity_err_a);
    n_ovr_a   = n_ovr_a + int'(overrun_a);
    n_busy_a  = n_busy_a + int'(busy_a);
    n_valid_p = n_valid_p + int'(m_valid_p);
    n_ferr_p  = n_ferr_p + int'(frame_err_p);
    n_perr_p  = n_perr_p + int'(parity_err_p);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit to_p, input logic v);
    if (to_p) rx_p = v;
    else rx_a = v;
    repeat (CPB) tick();
  endtask

  // par_bit < 0 means no parity bit on the line.
  task automatic send_frame(input bit to_p, input logic [7:0] d, input int par_bit, input logic stop_v);
    drive_bit(to_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_p, d[i]);
    if (par_bit >= 0) drive_bit(to_p, par_bit[0]);
    drive_bit(to_p, stop_v);
    if (to_p) rx_p = 1'b1;
    else rx_a = 1'b1;
  endtask

  task automatic wait_obs(input bit to_p, output bit got);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if ((to_p ? q_obs_p.size() : q_obs_a.size()) > 0) got = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({m_valid_a, busy_a, frame_err_a, parity_err_a, overrun_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags_a: got %b expected 00000",
               {m_valid_a, busy_a, frame_err_a, parity_err_a, overrun_a});
    end
    checks++;
    if (m_data_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_a: got %h expected 00", m_data_a);
    end
    checks++;
    if ({m_valid_p, busy_p, frame_err_p, parity_err_p, overrun_p, m_data_p} !== 13'b0) begin
      errors++;
      $display("FAIL reset_p: got %b expected all zero",
               {m_valid_p, busy_p, frame_err_p, parity_err_p, overrun_p, m_data_p});
    end
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    logic [7:0] pats[3];
    logic [7:0] e, o;
    bit got;
    int v0, f0, p0;
    pats[0] = 8'hA5; pats[1] = 8'h00; pats[2] = 8'hFF;
    m_ready_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v0 = n_valid_a; f0 = n_ferr_a; p0 = n_perr_a;
      q_exp_a.push_back(pats[k]);
      send_frame(1'b0, pats[k], -1, 1'b1);
      wait_obs(1'b0, got);
      repeat (6) tick();
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL basic_timeout: no word for %h", pats[k]);
        void'(q_exp_a.pop_front());
      end else begin
        e = q_exp_a.pop_front();
        o = q_obs_a.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL basic_data: got %h expected %h", o, e);
        end
      end
      checks++;
      if (n_valid_a - v0 != 1) begin
        errors++;
        $display("FAIL basic_valid_len: got %0d cycles expected 1", n_valid_a - v0);
      end
      checks++;
      if ((n_ferr_a - f0) + (n_perr_a - p0) != 0) begin
        errors++;
        $display("FAIL basic_err_pulses: got %0d expected 0", (n_ferr_a - f0) + (n_perr_a - p0));
      end
    end
  endtask

  task automatic test_glitch();
    int v0, f0, p0, b0;
    v0 = n_valid_a; f0 = n_ferr_a; p0 = n_perr_a; b0 = n_busy_a;
    rx_a = 1'b0;
    tick();
    rx_a = 1'b1;
    repeat (12) tick();
    checks++;
    if (n_busy_a - b0 == 0) begin
      errors++;
      $display("FAIL glitch_busy_pulse: got 0 busy cycles expected >0");
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: busy got %b expected 0", busy_a);
    end
    checks++;
    if ((n_valid_a - v0) + (n_ferr_a - f0) + (n_perr_a - p0) != 0) begin
      errors++;
      $display("FAIL glitch_outputs: got %0d valid/err cycles expected 0",
               (n_valid_a - v0) + (n_ferr_a - f0) + (n_perr_a - p0));
    end
  endtask

  task automatic test_frame_err();
    int v0, f0, p0;
    v0 = n_valid_a; f0 = n_ferr_a; p0 = n_perr_a;
    send_frame(1'b0, 8'h3C, -1, 1'b0);
    repeat (10) tick();
    checks++;
    if (n_ferr_a - f0 != 1) begin
      errors++;
      $display("FAIL frame_err_pulse: got %0d cycles expected 1", n_ferr_a - f0);
    end
    checks++;
    if ((n_valid_a - v0) + (n_perr_a - p0) != 0) begin
      errors++;
      $display("FAIL frame_err_no_valid: got %0d valid/perr cycles expected 0",
               (n_valid_a - v0) + (n_perr_a - p0));
    end
  endtask

  task automatic test_parity();
    logic [7:0] e, o;
    bit got;
    int v0, f0, p0;
    m_ready_p = 1'b1;
    v0 = n_valid_p; f0 = n_ferr_p; p0 = n_perr_p;
    send_frame(1'b1, 8'h01, 0, 1'b1);
    repeat (10) tick();
    checks++;
    if (n_perr_p - p0 != 1 || n_ferr_p - f0 != 0) begin
      errors++;
      $display("FAIL parity_bad: perr %0d ferr %0d expected 1 and 0", n_perr_p - p0, n_ferr_p - f0);
    end
    checks++;
    if (n_valid_p - v0 != 0) begin
      errors++;
      $display("FAIL parity_bad_valid: got %0d expected 0", n_valid_p - v0);
    end
    q_exp_p.push_back(8'h01);
    q_exp_p.push_back(8'h03);
    p0 = n_perr_p;
    send_frame(1'b1, 8'h01, 1, 1'b1);
    send_frame(1'b1, 8'h03, 0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_obs(1'b1, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL parity_good_timeout: word %0d missing", k);
        void'(q_exp_p.pop_front());
      end else begin
        e = q_exp_p.pop_front();
        o = q_obs_p.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL parity_good_data: got %h expected %h", o, e);
        end
      end
    end
    repeat (6) tick();
    checks++;
    if (n_perr_p - p0 != 0) begin
      errors++;
      $display("FAIL parity_good_perr: got %0d expected 0", n_perr_p - p0);
    end
    // Bad parity and bad stop together: only the framing error is reported.
    f0 = n_ferr_p; p0 = n_perr_p;
    send_frame(1'b1, 8'h01, 0, 1'b0);
    repeat (10) tick();
    checks++;
    if (n_ferr_p - f0 != 1 || n_perr_p - p0 != 0) begin
      errors++;
      $display("FAIL precedence: ferr %0d perr %0d expected 1 and 0", n_ferr_p - f0, n_perr_p - p0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] e, o;
    int r0;
    r0 = n_ovr_a;
    m_ready_a = 1'b0;
    q_exp_a.push_back(8'h11);
    send_frame(1'b0, 8'h11, -1, 1'b1);
    send_frame(1'b0, 8'h22, -1, 1'b1);
    repeat (8) tick();
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 8'h11) begin
      errors++;
      $display("FAIL overrun_hold: valid %b data %h expected 1 and 11", m_valid_a, m_data_a);
    end
    checks++;
    if (n_ovr_a - r0 != 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d cycles expected 1", n_ovr_a - r0);
    end
    m_ready_a = 1'b1;
    tick();
    checks++;
    if (m_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: valid got %b expected 0", m_valid_a);
    end
    checks++;
    if (q_obs_a.size() != 1) begin
      errors++;
      $display("FAIL overrun_accept_count: got %0d expected 1", q_obs_a.size());
      q_obs_a.delete();
      q_exp_a.delete();
    end else begin
      e = q_exp_a.pop_front();
      o = q_obs_a.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL overrun_data: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, e, o;
    bit got;
    int v0, f0, p0;
    d = 8'h5A;
    m_ready_a = 1'b1;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, d[i]);
    rx_a = d[3];
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({m_valid_a, busy_a, frame_err_a, parity_err_a, overrun_a, m_data_a} !== 13'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected all zero",
               {m_valid_a, busy_a, frame_err_a, parity_err_a, overrun_a, m_data_a});
    end
    rx_a = 1'b1;
    reset = 1'b0;
    v0 = n_valid_a; f0 = n_ferr_a; p0 = n_perr_a;
    repeat (3 * CPB) tick();
    checks++;
    if (busy_a !== 1'b0 || (n_valid_a - v0) + (n_ferr_a - f0) + (n_perr_a - p0) != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: busy %b pulses %0d expected 0 and 0",
               busy_a, (n_valid_a - v0) + (n_ferr_a - f0) + (n_perr_a - p0));
    end
    q_exp_a.push_back(d);
    send_frame(1'b0, d, -1, 1'b1);
    wait_obs(1'b0, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reset_mid_timeout: no word after reset");
      void'(q_exp_a.pop_front());
    end else begin
      e = q_exp_a.pop_front();
      o = q_obs_a.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_data: got %h expected %h", o, e);
      end
    end
    repeat (6) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e, o;
    bit got;
    int f0;
    f0 = n_ferr_a + n_perr_a + n_ovr_a;
    m_ready_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 8'h81 : 8'($urandom_range(0, 255));
      q_exp_a.push_back(d);
      send_frame(1'b0, d, -1, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      wait_obs(1'b0, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL b2b_timeout: word %0d missing", k);
        void'(q_exp_a.pop_front());
      end else begin
        e = q_exp_a.pop_front();
        o = q_obs_a.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL b2b_data: word %0d got %h expected %h", k, o, e);
        end
      end
    end
    repeat (6) tick();
    checks++;
    if (n_ferr_a + n_perr_a + n_ovr_a - f0 != 0) begin
      errors++;
      $display("FAIL b2b_err_pulses: got %0d expected 0", n_ferr_a + n_perr_a + n_ovr_a - f0);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_a = 1'b1;
    rx_p = 1'b1;
    m_ready_a = 1'b1;
    m_ready_p = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
